// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, frame
// width and the oversample tick divider calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Clock cycles per oversample tick (integer division, truncating).
  function automatic int calc_tick_div(input int clk_freq, input int baud,
                                       input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running tick divider: counts 0..TICK_DIV-1 and raises tick for one
// clk at the wrap. A synchronous clear realigns the phase. Also reused by the
// transmitter with OVERSAMPLE=1.
module uart_rx_tick #(
  parameter int TICK_DIV = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_LAST);

  // Divider counter: wraps at the tick, restarts on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver, LSB first, 1 start / 1 stop bit, mid-bit sampling from
// an oversample tick. Valid/ready output with framing and overrun pulses.
// Optional parity (macro UART_RX_PARITY_EN): adds a PARITY state, the
// PARITY_ODD parameter and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int                TICK_DIV  = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int                SCNT_W    = $clog2(OVERSAMPLE);
  localparam int                BCNT_W    = $clog2(DATA_BITS);
  localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] FULL_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 tick;
  logic                 tick_clr;
  rx_state_e            state_q, state_d;
  logic [SCNT_W-1:0]    scnt_q;
  logic [BCNT_W-1:0]    bcnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 half_done;
  logic                 bit_done;
  logic                 data_sample;
  logic                 stop_sample;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  uart_rx_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign half_done = tick && (scnt_q == HALF_LAST);
  assign bit_done  = tick && (scnt_q == FULL_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rx_s) state_d = START;
      START:     if (half_done) state_d = rx_s ? IDLE : DATA;
      DATA:
        if (bit_done && (bcnt_q == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (bit_done) state_d = STOP;
`endif
      STOP:      if (bit_done) state_d = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs: status and datapath strobes.
  always_comb begin
    busy        = (state_q != IDLE);
    tick_clr    = (state_q == IDLE) && !rx_s;
    data_sample = (state_q == DATA) && bit_done;
    stop_sample = (state_q == STOP) && bit_done;
  end

  // Sample/bit counters and shift register; shift fills from bit 7 (LSB first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
    end else begin
      if (state_q == IDLE || state_q == WAIT_IDLE ||
          (state_q == START && half_done) || bit_done) begin
        scnt_q <= '0;
      end else if (tick) begin
        scnt_q <= scnt_q + 1'b1;
      end

      if (state_q != DATA) bcnt_q <= '0;
      else if (bit_done)   bcnt_q <= bcnt_q + 1'b1;

      if (data_sample) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic par_bad;

  // Captured parity bit from the PARITY state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              par_q <= 1'b0;
    else if ((state_q == PARITY) && bit_done) par_q <= rx_s;
  end

  assign par_bad = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif

  // Output register: byte handoff, handshake and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (stop_sample) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if (par_bad) begin
          parity_err <= 1'b1;
`endif
        end else if (!rx_valid || rx_ready) begin
          // A same-cycle acceptance frees the slot, so the new byte loads.
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes into a queue,
// a monitor pops and compares each byte the DUT presents and counts error
// pulses. Define UART_RX_PARITY_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_bit_flip = 1'b0;
`endif

  uart_rx #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ODD(1'b0)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int         n_bytes = 0;
  int         n_frame = 0;
  int         n_over = 0;
  int         n_par = 0;
  logic       valid_prev = 1'b0;
  logic       acc_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: a byte is newly presented when valid rises or follows a transfer.
  always @(negedge clk) begin
    if (rx_valid && (!valid_prev || acc_prev)) begin
      n_bytes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        check("byte", {24'd0, rx_data}, {24'd0, exp_b});
      end
    end
    if (frame_err) n_frame++;
    if (overrun)   n_over++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_par++;
`endif
    valid_prev = rx_valid;
    acc_prev   = rx_valid && rx_ready;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    wait_clk(n);
  endtask

  // Full frame; the stop level is held for stop_bits bit periods.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int stop_bits);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_bit_flip, BIT);
`endif
    drive_bit(stop_b, stop_bits * BIT);
    rx = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !rx_valid; i++) wait_clk(1);
    check(name, {31'd0, rx_valid}, 32'd1);
  endtask

  task automatic accept(input string name);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    check(name, {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int nf;
    int no;
    logic [7:0] d77;
    d77 = 8'h77;

    // Reset state
    wait_clk(3);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_errs", {30'd0, frame_err, overrun}, 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // T1: single byte, consumer not ready
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1);
    wait_valid("t1_valid", BIT);
    check("t1_data", {24'd0, rx_data}, 32'hA5);
    wait_clk(BIT);
    check("t1_valid_held", {31'd0, rx_valid}, 32'd1);
    check("t1_no_err", n_frame + n_over, 0);
    accept("t1_accept");

    // T2: overrun keeps the first byte
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1);
    send_frame(8'h81, 1'b1, 1);
    wait_clk(BIT);
    check("t2_overrun", n_over, 1);
    check("t2_data", {24'd0, rx_data}, 32'h3C);
    accept("t2_accept");

    // T3: false start then a clean frame
    nb = n_bytes;
    rx = 1'b0;
    wait_clk(60);
    rx = 1'b1;
    wait_clk(2 * BIT);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_no_byte", n_bytes, nb);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1);
    wait_valid("t3_valid", BIT);
    accept("t3_accept");

    // T4: framing error on a held-low line, then recovery
    nb = n_bytes;
    nf = n_frame;
    send_frame(8'hF0, 1'b0, 3);
    wait_clk(2 * BIT);
    check("t4_frame_err", n_frame, nf + 1);
    check("t4_no_byte", n_bytes, nb);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1);
    wait_valid("t4_valid", BIT);
    check("t4_data", {24'd0, rx_data}, 32'h0F);

    // T5: reset in the middle of 0x77 while 0x0F is still held
    nf = n_frame;
    no = n_over;
    drive_bit(1'b0, BIT);
    drive_bit(d77[0], BIT);
    drive_bit(d77[1], BIT / 2);
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    check("t5_valid_pre", {31'd0, rx_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("t5_rst_data", {24'd0, rx_data}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    wait_clk(BIT / 2);
    for (int i = 2; i < 8; i++) drive_bit(d77[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d77, BIT);
`endif
    drive_bit(1'b1, BIT / 2);
    rst_n = 1'b1;
    nb = n_bytes;
    wait_clk(BIT / 2 + 2 * BIT);
    check("t5_no_byte", n_bytes, nb);
    check("t5_no_err", (n_frame - nf) + (n_over - no), 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1);
    wait_valid("t5_valid", BIT);
    accept("t5_accept");

`ifdef UART_RX_PARITY_EN
    // T6: even parity, wrong then right parity bit for 0x07
    nb = n_bytes;
    par_bit_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1);
    wait_clk(BIT);
    check("t6_parity_err", n_par, 1);
    check("t6_no_byte", n_bytes, nb);
    par_bit_flip = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1);
    wait_valid("t6_valid", BIT);
    check("t6_data", {24'd0, rx_data}, 32'h07);
    accept("t6_accept");
`endif

    wait_clk(10);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
